// File: rtl/lc3_pkg.sv
// ---------------------------------------------------------------------------
// lc3_pkg
// Shared definitions for the stream multiplexer and its arbiter.
//   LC3_WORD_W  : default data word width
//   arb_mode_e  : arbitration mode (round-robin or fixed priority)
//   idx_w()     : width of a channel index, never less than one bit
// ---------------------------------------------------------------------------
package lc3_pkg;

  localparam int LC3_WORD_W = 16;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Request arbiter for stream_mux_rr. Grant is purely combinational from the
// request vector and the priority pointer; the pointer register lives here.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (clears the pointer)
//   req      : per-channel request
//   advance  : a transfer happens on the granted channel this cycle
//   gnt      : one-hot grant (all-zero when nothing requests)
//   gnt_idx  : binary index of the granted channel
//   ptr      : current priority pointer (first channel searched in RR mode)
// ---------------------------------------------------------------------------
module rr_arbiter
  import lc3_pkg::*;
#(
  parameter int        N_CH = 4,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int       CH_W = idx_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic [CH_W-1:0] ptr
);

  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_idx;
  logic            w_found;
  int              w_cand;

  // Walk the channels in search order and keep the first requester.
  // RR search starts at the pointer and wraps; fixed priority starts at 0.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (MODE == ARB_FIXED) begin
        w_cand = k;
      end else begin
        w_cand = int'(r_ptr) + k;
        if (w_cand >= N_CH) w_cand = w_cand - N_CH;
      end
      if (!w_found && req[w_cand[CH_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (w_found) gnt[w_idx] = 1'b1;
  end

  assign gnt_idx = w_idx;
  assign ptr     = r_ptr;

  // Pointer moves just past the channel that was served; explicit wrap so
  // non-power-of-two channel counts stay in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      if (w_idx == CH_W'(N_CH - 1)) r_ptr <= '0;
      else                          r_ptr <= w_idx + CH_W'(1);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
// N_CH-input valid/ready stream multiplexer with a single registered output
// stage. One word per cycle can be sustained; the arbiter picks the channel.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : per-channel request
//   in_data    : packed channel words, channel i at [i*W +: W]
//   in_ready   : per-channel accept (at most one bit high)
//   out_valid  : output register holds a word
//   out_data   : selected word
//   out_ch     : index of the channel that supplied out_data
//   out_ready  : downstream accept
// ---------------------------------------------------------------------------
module stream_mux_rr
  import lc3_pkg::*;
#(
  parameter int        N_CH = 4,
  parameter int        W    = LC3_WORD_W,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int       CH_W = idx_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [CH_W-1:0]   out_ch,
  input  logic              out_ready
);

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [CH_W-1:0] r_out_ch;

  logic [N_CH-1:0] w_gnt;
  logic [CH_W-1:0] w_gnt_idx;
  logic [CH_W-1:0] w_ptr;
  logic            w_can_load;
  logic            w_xfer;
  logic [W-1:0]    w_sel_data;

  rr_arbiter #(
    .N_CH (N_CH),
    .MODE (MODE)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (w_xfer),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .ptr     (w_ptr)
  );

  // The output register can take a word when empty or when it drains this
  // same cycle. rst_n is folded in so no accept is signalled during reset.
  assign w_can_load = (!r_out_valid || out_ready) && rst_n;
  assign in_ready   = w_gnt & {N_CH{w_can_load}};
  assign w_xfer     = |in_ready;

  // Data never feeds the grant logic; it is only steered by the grant index.
  assign w_sel_data = in_data[int'(w_gnt_idx)*W +: W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_ch    <= w_gnt_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule
